// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that lets N requesters take turns writing bursts into one FIFO write port.
// A grant lasts until the burst ends, hits MAX_BURST beats, or the owner drops its request.
module fifo_wr_arb #(
   parameter int unsigned N         = 4,
   parameter int unsigned W         = 8,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic           wclk,
   input  logic           wrst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   last,
   input  logic [N*W-1:0] din,
   input  logic           full,
   output logic [N-1:0]   ack,
   output logic [N-1:0]   gnt,
   output logic           wen,
   output logic [W-1:0]   wdata,
   output logic           busy
);

   localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [GW-1:0]  g_q, g_d;
   logic [GW-1:0]  lw_q, lw_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [GW-1:0]  pick;
   logic [N-1:0]   pick_oh;
   logic           found;
   logic [N-1:0]   g_oh;
   logic           req_g, last_g;
   logic [W-1:0]   din_g;
   logic [CW-1:0]  cnt_inc;
   logic           wen_int;
   logic           rel;

   // Search upward from the slot after the last winner, wrapping around.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned idx;
         idx = (32'(lw_q) + k) % N;
         if (!found && req[GW'(idx)]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
      pick_oh       = '0;
      pick_oh[pick] = 1'b1;
   end

   always_comb begin
      g_oh      = '0;
      g_oh[g_q] = 1'b1;
      req_g     = 1'b0;
      last_g    = 1'b0;
      din_g     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (g_q == GW'(i)) begin
            req_g  = req[i];
            last_g = last[i];
            din_g  = din[i*W +: W];
         end
      end
   end

   assign busy    = (state_q == StBurst);
   assign wen_int = busy & req_g & ~full;
   assign cnt_inc = cnt_q + CW'(1);

   // Reset masks the write port in the same cycle, even mid-burst.
   assign wen   = wen_int & ~wrst;
   assign ack   = wen ? g_oh : '0;
   assign wdata = (busy && !wrst) ? din_g : '0;
   assign gnt   = gnt_q;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      g_d     = g_q;
      lw_d    = lw_q;
      cnt_d   = cnt_q;
      rel     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StBurst;
               gnt_d   = pick_oh;
               g_d     = pick;
               cnt_d   = '0;
            end
         end
         StBurst: begin
            // A dropped request wins over full; full alone only stalls.
            if (!req_g) begin
               rel = 1'b1;
            end else if (wen_int) begin
               cnt_d = cnt_inc;
               if (last_g || (cnt_inc == CW'(MAX_BURST))) rel = 1'b1;
            end
            if (rel) begin
               state_d = StIdle;
               gnt_d   = '0;
               lw_d    = g_q;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         g_q     <= '0;
         lw_q    <= GW'(N - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         g_q     <= g_d;
         lw_q    <= lw_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (N >= 2).
REQ-002 SHALL have parameter W, default 8, meaning data width per requester.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning maximum beats per grant (>= 1).
REQ-004 SHALL have port wclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port wrst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port req, input, N, where bit i means requester i presents a valid word.
REQ-007 SHALL have port last, input, N, where bit i means requester i's current word ends its burst.
REQ-008 SHALL have port din, input, N*W, holding requester i's word in bits [i*W +: W].
REQ-009 SHALL have port full, input, 1, the FIFO write-side full flag.
REQ-010 SHALL have port ack, output, N, where bit i means requester i's word is accepted this cycle.
REQ-011 SHALL have port gnt, output, N, a registered one-hot (or all-zero) grant.
REQ-012 SHALL have port wen, output, 1, the FIFO write enable.
REQ-013 SHALL have port wdata, output, W, the FIFO write data.
REQ-014 SHALL have port busy, output, 1, high while in state BURST.

Function
REQ-015 SHALL implement two states, IDLE and BURST, with a registered state, gnt, winner index g, last-winner pointer lw and beat counter cnt (width clog2(MAX_BURST+1)).
REQ-016 SHALL, in IDLE with any req bit set, select the first set bit searching upward from (lw+1) mod N with wrap-around, and register gnt=one-hot(g), state=BURST at the next edge; gnt stays zero in IDLE.
REQ-017 SHALL, in IDLE with req==0, remain in IDLE with gnt=0.
REQ-018 SHALL drive, combinationally in BURST, wen = req[g] & ~full and ack = one-hot(g) when wen=1, else zero.
REQ-019 SHALL drive wdata = din[g*W +: W] in BURST and all zeros in IDLE, regardless of wen.
REQ-020 SHALL increment cnt on each accepted beat (wen=1) and clear it on leaving BURST.
REQ-021 SHALL release the grant (next state IDLE, gnt=0, lw=g, cnt=0) when any of the following holds: an accepted beat has last[g]=1; an accepted beat makes cnt reach MAX_BURST; or req[g]=0.
REQ-022 SHALL hold the grant while full=1 with req[g]=1: no ack, cnt unchanged, gnt unchanged; full SHALL never cause release.
REQ-023 SHALL give precedence to req[g]=0 when it coincides with full=1, releasing the grant.
REQ-024 SHALL spend at least one IDLE cycle between consecutive grants, including re-grant to the same requester.
REQ-025 SHALL ignore req/last/din bits of non-granted requesters during BURST.
REQ-026 SHALL never assert more than one ack bit nor assert wen without a matching ack bit.

Reset
REQ-027 SHALL, at a rising wclk edge with wrst=1, set state=IDLE, gnt=0, cnt=0 and lw=N-1, so that requester 0 has first priority.
REQ-028 SHALL force wen=0, ack=0 and wdata=0 combinationally in any cycle where wrst=1, including mid-burst.
REQ-029 SHALL drive busy=0, wen=0, ack=0, gnt=0 and wdata=0 after reset.

Verification
REQ-030 SHALL cover fairness: after reset, req=4'b0101 held, last=4'b1111 -> gnt sequence 0001, 0000, 0100, 0000, 0001 with one ack per grant.
REQ-031 SHALL cover the burst cap: only req[0]=1, last=0, MAX_BURST=16 -> exactly 16 consecutive acks, one IDLE cycle, then gnt=0001 again.
REQ-032 SHALL cover backpressure: full=1 for 3 cycles at beat 5 of a req[1] burst -> wen=0 and ack=0 for 3 cycles, gnt=0010 held, cnt stays 5, and the burst resumes.
REQ-033 SHALL cover requester dropout: req[2] deasserted mid-burst with req[3]=1 -> gnt=0000 next cycle, then 1000.
REQ-034 SHALL cover mid-burst reset: wrst=1 during a gnt=0100 burst -> wen=0 the same cycle, gnt=0 after the edge, and the next arbitration with req=4'b1111 grants 0001.
REQ-035 SHALL cover single-beat and data routing: distinct din per requester -> wdata equals the granted requester's word on every wen cycle, and last on beat 1 releases after exactly 1 ack.
